// File: rtl/mul_hazard_fwd_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_hazard_fwd_unit_pkg
//  Description : Shared definitions for the MUL-aware hazard/forwarding unit.
//                Holds the EX operand-mux select encodings and the in-flight
//                multiply scoreboard slot record.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_hazard_fwd_unit_pkg;

   // EX operand mux selects
   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_MEM_WB = 2'b01;
   localparam logic [1:0] FWD_EX_MEM = 2'b10;
   localparam logic [1:0] FWD_MUL    = 2'b11;

   // Slot rd field is sized for the widest supported register address;
   // narrower addresses are zero-extended on entry. REG_ADDR_W must not
   // exceed SLOT_AW.
   localparam int SLOT_AW = 8;

   typedef struct packed {
      logic               valid;
      logic [SLOT_AW-1:0] rd;
   } slot_t;

endpackage
`default_nettype wire

// File: rtl/mul_hazard_fwd_unit_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : mul_hazard_fwd_unit_scoreboard
//  Description : Shift-register scoreboard of in-flight multiplies.
//                MUL_LAT-1 slots; slot[0] captures the MUL issuing from
//                ID/EX, slot[MUL_LAT-2] is the completing (done) slot.
//  Ports       : clk_i/arst_i     clock, async active-high reset
//                issue_i/issue_rd_i  MUL entering the multiplier this cycle
//                src_i            ID-stage source addresses (NUM_SRC packed)
//                dst_i            ID-stage destination address
//                raw_hit_o        per source: hit in a slot too young to forward
//                waw_hit_o        ID dst hits a slot that would retire too late
//                done_valid_o/done_rd_o  completing MUL
//                busy_o           any MUL issuing or in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_hazard_fwd_unit_scoreboard
   import mul_hazard_fwd_unit_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int REG_ADDR_W = 5,
   parameter int MUL_LAT    = 4
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic                          issue_i,
   input  logic [REG_ADDR_W-1:0]         issue_rd_i,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_i,
   input  logic [REG_ADDR_W-1:0]         dst_i,
   output logic [NUM_SRC-1:0]            raw_hit_o,
   output logic                          waw_hit_o,
   output logic                          done_valid_o,
   output logic [REG_ADDR_W-1:0]         done_rd_o,
   output logic                          busy_o
);

   localparam int NSLOT = MUL_LAT - 1;

   slot_t [NSLOT-1:0] slot_q;
   slot_t [NSLOT-1:0] slot_d;

   always_comb begin
      slot_d          = '0;
      slot_d[0].valid = issue_i;
      slot_d[0].rd    = issue_i ? SLOT_AW'(issue_rd_i) : '0;
      for (int j = 1; j < NSLOT; j++) begin
         slot_d[j] = slot_q[j-1];
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   // Slots 0..MUL_LAT-4 cannot supply a result in time for an ID reader;
   // slot MUL_LAT-3 will be the done slot when that reader reaches EX.
   // For WAW, any slot that has not yet reached the done slot would retire
   // after a younger writer in ID.
   always_comb begin
      raw_hit_o = '0;
      waw_hit_o = 1'b0;
      busy_o    = issue_i;
      for (int j = 0; j < NSLOT; j++) begin
         busy_o = busy_o | slot_q[j].valid;
         if (j <= MUL_LAT - 3) begin
            waw_hit_o = waw_hit_o |
                        (slot_q[j].valid && (slot_q[j].rd == SLOT_AW'(dst_i)));
         end
         if (j <= MUL_LAT - 4) begin
            for (int s = 0; s < NUM_SRC; s++) begin
               raw_hit_o[s] = raw_hit_o[s] |
                  (slot_q[j].valid &&
                   (slot_q[j].rd == SLOT_AW'(src_i[s*REG_ADDR_W +: REG_ADDR_W])));
            end
         end
      end
   end

   assign done_valid_o = slot_q[NSLOT-1].valid;
   assign done_rd_o    = slot_q[NSLOT-1].valid ?
                         slot_q[NSLOT-1].rd[REG_ADDR_W-1:0] : '0;

endmodule
`default_nettype wire

// File: rtl/mul_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_hazard_fwd_unit
//  Description : Hazard detection and EX forwarding for a 5-stage pipeline
//                with a pipelined MUL_LAT-cycle multiplier. Stalls ID on
//                load-use, unresolved MUL RAW and MUL WAW hazards; selects
//                EX operand sources including the multiplier output.
//  Ports       : *_IF_ID_i  instruction in ID     *_ID_EX_i  instruction in EX
//                *_EX_MEM_i / *_MEM_WB_i  later stages
//                stall_o, forward_o (2 bits per source), mul_done_o/mul_rd_o,
//                sb_busy_o, stall_cnt_mul_o / stall_cnt_load_o
//  Config      : HAZARD_STATS_EN - enables saturating stall counters;
//                otherwise the counter ports are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_hazard_fwd_unit
   import mul_hazard_fwd_unit_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int REG_ADDR_W = 5,
   parameter int MUL_LAT    = 4
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_IF_ID_i,
   input  logic [NUM_SRC-1:0]            rs_used_IF_ID_i,
   input  logic [REG_ADDR_W-1:0]         rd_IF_ID_i,
   input  logic                          reg_write_IF_ID_i,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ID_EX_i,
   input  logic [REG_ADDR_W-1:0]         rd_ID_EX_i,
   input  logic                          reg_write_ID_EX_i,
   input  logic                          mem_read_ID_EX_i,
   input  logic                          is_mul_ID_EX_i,
   input  logic                          kill_ID_EX_i,
   input  logic [REG_ADDR_W-1:0]         rd_EX_MEM_i,
   input  logic                          reg_write_EX_MEM_i,
   input  logic [REG_ADDR_W-1:0]         rd_MEM_WB_i,
   input  logic                          reg_write_MEM_WB_i,
   output logic                          stall_o,
   output logic [2*NUM_SRC-1:0]          forward_o,
   output logic                          mul_done_o,
   output logic [REG_ADDR_W-1:0]         mul_rd_o,
   output logic                          sb_busy_o,
   output logic [31:0]                   stall_cnt_mul_o,
   output logic [31:0]                   stall_cnt_load_o
);

   logic                  w_issue;
   logic [NUM_SRC-1:0]    w_sb_raw_hit;
   logic                  w_sb_waw_hit;
   logic                  w_done_valid;
   logic [REG_ADDR_W-1:0] w_done_rd;
   logic                  w_raw_mul;
   logic                  w_load_use;
   logic                  w_waw;

   // Killed MULs and MULs to x0 never occupy the scoreboard.
   assign w_issue = is_mul_ID_EX_i & reg_write_ID_EX_i & ~kill_ID_EX_i &
                    (rd_ID_EX_i != '0);

   mul_hazard_fwd_unit_scoreboard #(
      .NUM_SRC    (NUM_SRC),
      .REG_ADDR_W (REG_ADDR_W),
      .MUL_LAT    (MUL_LAT)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .arst_i       (arst_i),
      .issue_i      (w_issue),
      .issue_rd_i   (rd_ID_EX_i),
      .src_i        (rs_IF_ID_i),
      .dst_i        (rd_IF_ID_i),
      .raw_hit_o    (w_sb_raw_hit),
      .waw_hit_o    (w_sb_waw_hit),
      .done_valid_o (w_done_valid),
      .done_rd_o    (w_done_rd),
      .busy_o       (sb_busy_o)
   );

   // ID source hazards; unread sources and x0 are ignored.
   always_comb begin
      logic [REG_ADDR_W-1:0] v_rs;
      w_raw_mul  = 1'b0;
      w_load_use = 1'b0;
      v_rs       = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         v_rs = rs_IF_ID_i[s*REG_ADDR_W +: REG_ADDR_W];
         if (rs_used_IF_ID_i[s] && (v_rs != '0)) begin
            // With MUL_LAT == 2 the issuing MUL is already the done slot
            // when this reader reaches EX, so it need not wait.
            w_raw_mul  = w_raw_mul | w_sb_raw_hit[s] |
                         ((MUL_LAT >= 3) && w_issue && (v_rs == rd_ID_EX_i));
            w_load_use = w_load_use |
                         (mem_read_ID_EX_i && (rd_ID_EX_i != '0) &&
                          (v_rs == rd_ID_EX_i));
         end
      end
   end

   assign w_waw = reg_write_IF_ID_i && (rd_IF_ID_i != '0) &&
                  ((w_issue && (rd_IF_ID_i == rd_ID_EX_i)) || w_sb_waw_hit);

   assign stall_o = w_raw_mul | w_load_use | w_waw;

   // EX operand selects: youngest producer wins.
   always_comb begin
      logic [REG_ADDR_W-1:0] v_src;
      forward_o = '0;
      v_src     = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         v_src = rs_ID_EX_i[s*REG_ADDR_W +: REG_ADDR_W];
         if (v_src != '0) begin
            if (reg_write_EX_MEM_i && (rd_EX_MEM_i == v_src)) begin
               forward_o[2*s +: 2] = FWD_EX_MEM;
            end else if (reg_write_MEM_WB_i && (rd_MEM_WB_i == v_src)) begin
               forward_o[2*s +: 2] = FWD_MEM_WB;
            end else if (w_done_valid && (w_done_rd == v_src)) begin
               forward_o[2*s +: 2] = FWD_MUL;
            end else begin
               forward_o[2*s +: 2] = FWD_RF;
            end
         end
      end
   end

   assign mul_done_o = w_done_valid;
   assign mul_rd_o   = w_done_rd;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_mul_q,  stall_cnt_mul_d;
   logic [31:0] stall_cnt_load_q, stall_cnt_load_d;

   // A cycle with both a MUL-related and a load-use cause counts as MUL.
   always_comb begin
      stall_cnt_mul_d  = stall_cnt_mul_q;
      stall_cnt_load_d = stall_cnt_load_q;
      if ((w_raw_mul || w_waw) && (stall_cnt_mul_q != 32'hFFFF_FFFF)) begin
         stall_cnt_mul_d = stall_cnt_mul_q + 32'd1;
      end
      if (w_load_use && !(w_raw_mul || w_waw) &&
          (stall_cnt_load_q != 32'hFFFF_FFFF)) begin
         stall_cnt_load_d = stall_cnt_load_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         stall_cnt_mul_q  <= '0;
         stall_cnt_load_q <= '0;
      end else begin
         stall_cnt_mul_q  <= stall_cnt_mul_d;
         stall_cnt_load_q <= stall_cnt_load_d;
      end
   end

   assign stall_cnt_mul_o  = stall_cnt_mul_q;
   assign stall_cnt_load_o = stall_cnt_load_q;
`else
   assign stall_cnt_mul_o  = '0;
   assign stall_cnt_load_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_hazard_fwd_unit
//  Description : Self-checking bench for mul_hazard_fwd_unit (MUL_LAT=4).
//                An age-based model of in-flight MULs predicts each cycle's
//                outputs; predictions are queued and compared at negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_hazard_fwd_unit;

   localparam int NUM_SRC    = 2;
   localparam int REG_ADDR_W = 5;
   localparam int MUL_LAT    = 4;

   logic        clk = 1'b0;
   logic        arst;
   logic [9:0]  rs_IF_ID;
   logic [1:0]  rs_used;
   logic [4:0]  rd_IF_ID;
   logic        rw_IF_ID;
   logic [9:0]  rs_ID_EX;
   logic [4:0]  rd_ID_EX;
   logic        rw_ID_EX;
   logic        mem_read;
   logic        is_mul;
   logic        kill;
   logic [4:0]  rd_EX_MEM;
   logic        rw_EX_MEM;
   logic [4:0]  rd_MEM_WB;
   logic        rw_MEM_WB;

   logic        stall;
   logic [3:0]  forward;
   logic        mul_done;
   logic [4:0]  mul_rd;
   logic        sb_busy;
   logic [31:0] cnt_mul;
   logic [31:0] cnt_load;

   always #5 clk = ~clk;

   mul_hazard_fwd_unit #(
      .NUM_SRC    (NUM_SRC),
      .REG_ADDR_W (REG_ADDR_W),
      .MUL_LAT    (MUL_LAT)
   ) dut (
      .clk_i              (clk),
      .arst_i             (arst),
      .rs_IF_ID_i         (rs_IF_ID),
      .rs_used_IF_ID_i    (rs_used),
      .rd_IF_ID_i         (rd_IF_ID),
      .reg_write_IF_ID_i  (rw_IF_ID),
      .rs_ID_EX_i         (rs_ID_EX),
      .rd_ID_EX_i         (rd_ID_EX),
      .reg_write_ID_EX_i  (rw_ID_EX),
      .mem_read_ID_EX_i   (mem_read),
      .is_mul_ID_EX_i     (is_mul),
      .kill_ID_EX_i       (kill),
      .rd_EX_MEM_i        (rd_EX_MEM),
      .reg_write_EX_MEM_i (rw_EX_MEM),
      .rd_MEM_WB_i        (rd_MEM_WB),
      .reg_write_MEM_WB_i (rw_MEM_WB),
      .stall_o            (stall),
      .forward_o          (forward),
      .mul_done_o         (mul_done),
      .mul_rd_o           (mul_rd),
      .sb_busy_o          (sb_busy),
      .stall_cnt_mul_o    (cnt_mul),
      .stall_cnt_load_o   (cnt_load)
   );

   typedef struct {
      logic        stall;
      logic [3:0]  fwd;
      logic        done;
      logic [4:0]  mrd;
      logic        busy;
      logic [31:0] cm;
      logic [31:0] cl;
   } exp_t;

   // age 1 = slot[0]; age MUL_LAT-1 = completing this cycle
   typedef struct {
      int         age;
      logic [4:0] rd;
   } mul_t;

   exp_t        exp_q[$];
   mul_t        fl[$];
   logic [31:0] m_cm = '0;
   logic [31:0] m_cl = '0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic idle();
      rs_IF_ID  = '0; rs_used  = '0; rd_IF_ID = '0; rw_IF_ID = 1'b0;
      rs_ID_EX  = '0; rd_ID_EX = '0; rw_ID_EX = 1'b0; mem_read = 1'b0;
      is_mul    = 1'b0; kill   = 1'b0;
      rd_EX_MEM = '0; rw_EX_MEM = 1'b0; rd_MEM_WB = '0; rw_MEM_WB = 1'b0;
   endtask

   task automatic step();
      exp_t       e;
      exp_t       got;
      logic       issue, raw, waw, ld;
      logic [4:0] r;
      mul_t       nf[$];

      issue = is_mul && rw_ID_EX && !kill && (rd_ID_EX != 5'd0);
      raw = 1'b0; ld = 1'b0; waw = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         r = rs_IF_ID[s*5 +: 5];
         if (rs_used[s] && r != 5'd0) begin
            if (MUL_LAT >= 3 && issue && r == rd_ID_EX) raw = 1'b1;
            foreach (fl[k]) if (fl[k].age <= MUL_LAT-3 && fl[k].rd == r) raw = 1'b1;
            if (mem_read && rd_ID_EX != 5'd0 && r == rd_ID_EX) ld = 1'b1;
         end
      end
      if (rw_IF_ID && rd_IF_ID != 5'd0) begin
         if (issue && rd_IF_ID == rd_ID_EX) waw = 1'b1;
         foreach (fl[k]) if (fl[k].age <= MUL_LAT-2 && fl[k].rd == rd_IF_ID) waw = 1'b1;
      end
      e.stall = raw | waw | ld;
      e.done  = 1'b0;
      e.mrd   = '0;
      foreach (fl[k]) if (fl[k].age == MUL_LAT-1) begin
         e.done = 1'b1;
         e.mrd  = fl[k].rd;
      end
      e.fwd = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         r = rs_ID_EX[s*5 +: 5];
         if (r != 5'd0) begin
            if (rw_EX_MEM && rd_EX_MEM == r)      e.fwd[2*s +: 2] = 2'b10;
            else if (rw_MEM_WB && rd_MEM_WB == r) e.fwd[2*s +: 2] = 2'b01;
            else if (e.done && e.mrd == r)        e.fwd[2*s +: 2] = 2'b11;
         end
      end
      e.busy = issue || (fl.size() != 0);
`ifdef HAZARD_STATS_EN
      e.cm = m_cm;
      e.cl = m_cl;
`else
      e.cm = '0;
      e.cl = '0;
`endif
      exp_q.push_back(e);

      @(negedge clk);
      got = exp_q.pop_front();
      check("stall",     stall,    got.stall);
      check("forward",   forward,  got.fwd);
      check("mul_done",  mul_done, got.done);
      check("mul_rd",    mul_rd,   got.mrd);
      check("sb_busy",   sb_busy,  got.busy);
      check("cnt_mul",   cnt_mul,  got.cm);
      check("cnt_load",  cnt_load, got.cl);

      @(posedge clk);
      if (arst) begin
         fl.delete();
         m_cm = '0;
         m_cl = '0;
      end else begin
         if (raw || waw) m_cm = m_cm + 1;
         else if (ld)    m_cl = m_cl + 1;
         foreach (fl[k]) if (fl[k].age < MUL_LAT-1)
            nf.push_back('{age: fl[k].age + 1, rd: fl[k].rd});
         if (issue) nf.push_back('{age: 1, rd: rd_ID_EX});
         fl = nf;
      end
      #1;
   endtask

   initial begin
      arst = 1'b0;
      idle();
      #1 arst = 1'b1;
      step(); step();
      arst = 1'b0;

      // MUL x5 issues; dependent ADD waits in ID, then takes the MUL path
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 5; rs_used = 2'b01; rs_IF_ID[4:0] = 5; step();
      idle(); rs_used = 2'b01; rs_IF_ID[4:0] = 5; step();
      idle(); rs_used = 2'b01; rs_IF_ID[4:0] = 5; step();
      idle(); rs_ID_EX[4:0] = 5; step();
      idle(); step();

      // load-use on rs2, then MEM/WB forward
      idle(); mem_read = 1; rw_ID_EX = 1; rd_ID_EX = 3; rs_used = 2'b10; rs_IF_ID[9:5] = 3; step();
      idle(); rw_EX_MEM = 1; rd_EX_MEM = 3; rs_used = 2'b10; rs_IF_ID[9:5] = 3; step();
      idle(); rw_MEM_WB = 1; rd_MEM_WB = 3; rs_ID_EX[9:5] = 3; step();

      // EX/MEM beats MEM/WB; mixed per-source selects
      idle(); rw_EX_MEM = 1; rd_EX_MEM = 7; rw_MEM_WB = 1; rd_MEM_WB = 7; rs_ID_EX = {5'd7, 5'd7}; step();
      idle(); rw_EX_MEM = 1; rd_EX_MEM = 7; rw_MEM_WB = 1; rd_MEM_WB = 8; rs_ID_EX = {5'd8, 5'd7}; step();

      // x0 never stalls or forwards
      idle(); rw_EX_MEM = 1; mem_read = 1; rw_ID_EX = 1; rs_used = 2'b11; step();

      // MEM/WB beats the done slot
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 6; step();
      idle(); step();
      idle(); step();
      idle(); rw_MEM_WB = 1; rd_MEM_WB = 6; rs_ID_EX = {5'd6, 5'd6}; step();

      // WAW on x9 until the MUL reaches the done slot
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 9; rw_IF_ID = 1; rd_IF_ID = 9; step();
      for (int i = 0; i < 3; i++) begin
         idle(); rw_IF_ID = 1; rd_IF_ID = 9; step();
      end

      // unread source matching an in-flight MUL does not stall
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 12; rs_IF_ID = {5'd12, 5'd12}; step();
      idle(); rs_IF_ID = {5'd12, 5'd12}; step();
      idle(); step(); idle(); step();

      // RAW-MUL and load-use in the same cycle
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 14; step();
      idle(); mem_read = 1; rw_ID_EX = 1; rd_ID_EX = 15; rs_used = 2'b11; rs_IF_ID = {5'd15, 5'd14}; step();
      idle(); rs_used = 2'b10; rs_IF_ID = {5'd20, 5'd0}; mem_read = 1; rw_ID_EX = 1; rd_ID_EX = 20; step();
      idle(); step(); idle(); step();

      // killed MUL never enters the scoreboard
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 13; kill = 1; step();
      for (int i = 0; i < 3; i++) begin
         idle(); step();
      end

      // asynchronous reset with two MULs in flight
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 10; step();
      idle(); is_mul = 1; rw_ID_EX = 1; rd_ID_EX = 11; step();
      idle();
      arst = 1'b1;
      #1 arst = 1'b0;
      fl.delete();
      m_cm = '0;
      m_cl = '0;
      for (int i = 0; i < 4; i++) begin
         idle(); step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
